// File: rtl/pipe_adder_arb8.sv
`timescale 1ns/1ps
// pipe_adder_arb8: round-robin arbiter that runs each requester's 8-bit add as two nibble
// passes through one shared pipelined 4-bit adder. Define ARB_STATS_EN for per-requester grant counters.
module pipe_adder_arb8 #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       cin0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       cin1,
    output logic       ack0,
    output logic       ack1,
    output logic       rsp_valid0,
    output logic       rsp_valid1,
    output logic [7:0] rsp_sum,
    output logic       rsp_cout,
    output logic       busy,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [3:0] add_s,
    input  logic       add_cout,
`ifdef ARB_STATS_EN
    output logic [7:0] gnt_cnt0,
    output logic [7:0] gnt_cnt1,
`endif
    output logic [2:0] dbg_state
);

    // Handshake: a requester holds req high with stable operands until its one-cycle ack.
    // Operands are latched at the grant edge, so they are free to change once ack is seen.
    // rsp_valid0/1 is a one-cycle pulse with no backpressure; rsp_sum/rsp_cout hold until the next result.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO      = 3'd1,
        S_WAIT_LO = 3'd2,
        S_HI      = 3'd3,
        S_WAIT_HI = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t     r_state;
    logic       r_rr_ptr;
    logic       r_gnt_id;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic       r_op_cin;
    logic [3:0] r_cnt;
    logic [3:0] r_sum_lo;
    logic [3:0] r_sum_hi;
    logic       r_c_mid;
    logic       r_c_fin;

    logic       w_any_req;
    logic       w_pick;

    assign w_any_req = req0 | req1;
    // r_rr_ptr names the requester that wins the next tie.
    assign w_pick    = (req0 && req1) ? r_rr_ptr : req1;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_gnt_id   <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_cin   <= 1'b0;
            r_cnt      <= '0;
            r_sum_lo   <= '0;
            r_sum_hi   <= '0;
            r_c_mid    <= 1'b0;
            r_c_fin    <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            busy       <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            busy       <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_id <= w_pick;
                        r_rr_ptr <= ~w_pick;
                        r_op_a   <= w_pick ? a1 : a0;
                        r_op_b   <= w_pick ? b1 : b0;
                        r_op_cin <= w_pick ? cin1 : cin0;
                        r_state  <= S_LO;
                    end
                end
                S_LO: begin
                    ack0    <= ~r_gnt_id;
                    ack1    <= r_gnt_id;
                    add_a   <= r_op_a[3:0];
                    add_b   <= r_op_b[3:0];
                    add_cin <= r_op_cin;
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (r_cnt == 4'd0) begin
                        r_sum_lo <= add_s;
                        r_c_mid  <= add_cout;
                        r_state  <= S_HI;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HI: begin
                    add_a   <= r_op_a[7:4];
                    add_b   <= r_op_b[7:4];
                    add_cin <= r_c_mid;
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (r_cnt == 4'd0) begin
                        r_sum_hi <= add_s;
                        r_c_fin  <= add_cout;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    rsp_sum    <= {r_sum_hi, r_sum_lo};
                    rsp_cout   <= r_c_fin;
                    rsp_valid0 <= ~r_gnt_id;
                    rsp_valid1 <= r_gnt_id;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Counters advance on the same edge that raises the matching ack, and stick at 8'hFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (r_state == S_LO) begin
            if (!r_gnt_id && gnt_cnt0 != 8'hFF) gnt_cnt0 <= gnt_cnt0 + 8'd1;
            if (r_gnt_id && gnt_cnt1 != 8'hFF) gnt_cnt1 <= gnt_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_adder_arb8.sv
`timescale 1ns/1ps
// Bench for pipe_adder_arb8: shared-adder model, arbitration/arith reference model, scoreboard.
module tb_pipe_adder_arb8;

    localparam int LAT       = 2;
    localparam int ACK_LIMIT = 40;
    localparam int RSP_LIMIT = 4 * LAT + 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, cin0, cin1;
    logic [7:0] a0, b0, a1, b1;
    logic       ack0, ack1, rsp_valid0, rsp_valid1, rsp_cout, busy;
    logic [7:0] rsp_sum;
    logic [3:0] add_a, add_b, add_s;
    logic       add_cin, add_cout;
    logic [2:0] dbg_state;
`ifdef ARB_STATS_EN
    logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];
    logic [7:0] m_a[2];
    logic [7:0] m_b[2];
    logic       m_c[2];
    logic       m_pend[2];
    int         m_pref;
    int         m_gnt[2];
    logic [4:0] add_pipe[LAT-1];

    always #5 clk = ~clk;

    pipe_adder_arb8 #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .ack0(ack0), .ack1(ack1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
`ifdef ARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .dbg_state(dbg_state)
    );

    // Shared adder: result of operands present in cycle t is readable at the edge ending cycle t+LAT-1.
    always @(posedge clk) begin
        add_pipe[0] <= 5'(add_a) + 5'(add_b) + 5'(add_cin);
        for (int i = 1; i < LAT - 1; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign {add_cout, add_s} = add_pipe[LAT-2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic raise(input int id, input logic [7:0] a, input logic [7:0] b, input logic c);
        m_a[id]    = a;
        m_b[id]    = b;
        m_c[id]    = c;
        m_pend[id] = 1'b1;
        if (id == 0) begin
            a0 = a; b0 = b; cin0 = c; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; cin1 = c; req1 = 1'b1;
        end
    endtask

    task automatic raise_rand(input int id);
        raise(id, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    endtask

    task automatic reset_model();
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        m_pref    = 0;
        m_gnt[0]  = 0;
        m_gnt[1]  = 0;
        exp_q.delete();
    endtask

    // One grant/result: predicts the winner, checks ack, both nibble passes and the result.
    // Returns at the negedge of the rsp_valid cycle, where the DUT is already back in IDLE.
    task automatic serve_one(output logic [7:0] s, output logic c, output int gid);
        int         id;
        int         cyc;
        logic [8:0] full;
        logic       lo_carry;
        logic [9:0] exp;
        id       = (m_pend[0] && m_pend[1]) ? m_pref : (m_pend[1] ? 1 : 0);
        m_pref   = 1 - id;
        full     = 9'(m_a[id]) + 9'(m_b[id]) + 9'(m_c[id]);
        lo_carry = ((5'(m_a[id][3:0]) + 5'(m_b[id][3:0]) + 5'(m_c[id])) > 5'd15);
        m_gnt[id] = (m_gnt[id] < 255) ? m_gnt[id] + 1 : 255;
        exp_q.push_back({1'(id), full});

        cyc = 0;
        while (!(ack0 || ack1) && cyc < ACK_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        gid = ack1 ? 1 : 0;
        check("ack_seen", 32'(ack0 | ack1), 32'd1);
        check("ack_id", 32'(ack1), 32'(id));
        check("ack_excl", 32'(ack0 & ack1), 32'd0);
        check("busy_at_ack", 32'(busy), 32'd1);
        check("lo_add_a", 32'(add_a), 32'(m_a[id][3:0]));
        check("lo_add_b", 32'(add_b), 32'(m_b[id][3:0]));
        check("lo_add_cin", 32'(add_cin), 32'(m_c[id]));
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
        m_pend[id] = 1'b0;

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == LAT + 1) begin
                check("hi_add_a", 32'(add_a), 32'(m_a[id][7:4]));
                check("hi_add_b", 32'(add_b), 32'(m_b[id][7:4]));
                check("hi_add_cin", 32'(add_cin), 32'(lo_carry));
            end
        end while (!(rsp_valid0 || rsp_valid1) && cyc < RSP_LIMIT);
        check("rsp_seen", 32'(rsp_valid0 | rsp_valid1), 32'd1);
        check("rsp_lat", 32'(cyc), 32'(2 * LAT + 2));
        check("rsp_excl", 32'(rsp_valid0 & rsp_valid1), 32'd0);
        check("busy_at_rsp", 32'(busy), 32'd1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("rsp_id", 32'(rsp_valid1), 32'(exp[9]));
            check("rsp_sum", 32'(rsp_sum), 32'(exp[7:0]));
            check("rsp_cout", 32'(rsp_cout), 32'(exp[8]));
        end
        s = rsp_sum;
        c = rsp_cout;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] s;
        logic       c;
        int         gid;
        int         cyc;
        int         n_rsp;

        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_rsp_valid", 32'({rsp_valid1, rsp_valid0}), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Tie from reset, the served requester re-raising after its first result.
        raise_rand(0);
        raise_rand(1);
        for (int k = 0; k < 4; k++) begin
            serve_one(s, c, gid);
            check("tie_order", 32'(gid), 32'(k % 2));
            if (k < 2) raise_rand(gid);
        end

        raise(0, 8'h3A, 8'h1F, 1'b0);
        serve_one(s, c, gid);
        check("tp_3a_1f_sum", 32'(s), 32'h59);
        check("tp_3a_1f_cout", 32'(c), 32'd0);

        raise(1, 8'h0F, 8'h01, 1'b0);
        serve_one(s, c, gid);
        check("tp_0f_01_sum", 32'(s), 32'h10);
        check("tp_0f_01_cout", 32'(c), 32'd0);

        // Abort a transaction in WAIT_LO with an asynchronous reset.
        raise(0, 8'hA7, 8'h3C, 1'b1);
        cyc = 0;
        while (!ack0 && cyc < ACK_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        check("abort_add_a_pre", 32'(add_a), 32'h7);
        #1 rst = 1'b0;
        #1;
        check("async_ack", 32'({ack1, ack0}), 32'd0);
        check("async_rsp_valid", 32'({rsp_valid1, rsp_valid0}), 32'd0);
        check("async_rsp_sum", 32'(rsp_sum), 32'd0);
        check("async_rsp_cout", 32'(rsp_cout), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_add", 32'({add_a, add_b, add_cin}), 32'd0);
        check("async_state", 32'(dbg_state), 32'd0);
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_rsp = 0;
        repeat (2 * LAT + 8) begin
            @(negedge clk);
            if (rsp_valid0 || rsp_valid1) n_rsp++;
        end
        check("abort_no_rsp", 32'(n_rsp), 32'd0);
        check("abort_idle", 32'(dbg_state), 32'd0);
        raise(1, 8'h22, 8'h11, 1'b0);
        serve_one(s, c, gid);
        check("post_abort_id", 32'(gid), 32'd1);
        check("post_abort_sum", 32'(s), 32'h33);
        check("post_abort_cout", 32'(c), 32'd0);

        raise(0, 8'hFF, 8'h00, 1'b1);
        serve_one(s, c, gid);
        check("tp_ff_00_1_sum", 32'(s), 32'h00);
        check("tp_ff_00_1_cout", 32'(c), 32'd1);

        raise(0, 8'hF0, 8'h10, 1'b0);
        serve_one(s, c, gid);
        check("tp_f0_10_sum", 32'(s), 32'h00);
        check("tp_f0_10_cout", 32'(c), 32'd1);

        // Random traffic: requesters join at random whenever the arbiter is back in IDLE.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_pend[i] && $urandom_range(0, 1) == 1) raise_rand(i);
            end
            if (!m_pend[0] && !m_pend[1]) raise_rand(int'($urandom_range(0, 1)));
            serve_one(s, c, gid);
        end
        while (m_pend[0] || m_pend[1]) serve_one(s, c, gid);

`ifdef ARB_STATS_EN
        check("stats_cnt0_mid", 32'(gnt_cnt0), 32'(m_gnt[0]));
        check("stats_cnt1_mid", 32'(gnt_cnt1), 32'(m_gnt[1]));
        for (int n = 0; n < 300; n++) begin
            raise_rand(0);
            serve_one(s, c, gid);
        end
        check("stats_cnt0_sat", 32'(gnt_cnt0), 32'hFF);
        check("stats_cnt0_model", 32'(gnt_cnt0), 32'(m_gnt[0]));
        check("stats_cnt1_hold", 32'(gnt_cnt1), 32'(m_gnt[1]));
`endif

        repeat (3) @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
